// File: rtl/axis_insert_header_stream_if.sv
// -----------------------------------------------------------------------------
// axis_insert_header_stream_if
//
// Bundles the three handshake groups of the header inserter:
//   - input stream   : valid_in, data_in, keep_in, last_in, ready_in
//   - output stream  : valid_out, data_out, keep_out, last_out, ready_out
//   - header channel : valid_insert, header_insert, keep_insert,
//                      byte_insert_cnt, ready_insert
//
// Modports:
//   slave  - the inserter's view (consumes input stream and header,
//            produces output stream)
//   master - the environment's view (source, header provider and sink)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface axis_insert_header_stream_if #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) ();

    // input stream
    logic                    valid_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    logic                    ready_in;

    // output stream
    logic                    valid_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    logic                    ready_out;

    // header channel
    logic                    valid_insert;
    logic [DATA_WD-1:0]      header_insert;
    logic [DATA_BYTE_WD-1:0] keep_insert;
    logic [BYTE_CNT_WD:0]    byte_insert_cnt;
    logic                    ready_insert;

    modport slave (
        input  valid_in, data_in, keep_in, last_in,
        output ready_in,
        output valid_out, data_out, keep_out, last_out,
        input  ready_out,
        input  valid_insert, header_insert, keep_insert, byte_insert_cnt,
        output ready_insert
    );

    modport master (
        output valid_in, data_in, keep_in, last_in,
        input  ready_in,
        input  valid_out, data_out, keep_out, last_out,
        output ready_out,
        output valid_insert, header_insert, keep_insert, byte_insert_cnt,
        input  ready_insert
    );

endinterface

// File: rtl/axis_insert_header_stream.sv
// -----------------------------------------------------------------------------
// axis_insert_header_stream
//
// Prepends a 0..DATA_BYTE_WD-byte header to every AXI-Stream packet of
// arbitrary length at one beat per cycle. No packet buffer is used: a
// residual register holds the bytes that did not fit into the last emitted
// beat and is merged with the next input beat.
//
// Byte order: byte 0 of a beat sits in the MSBs and is sent first. Header
// bytes are the byte_insert_cnt LSB bytes of header_insert and are moved to
// the MSBs before merging.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset; drops any partial packet
//   bus  - axis_insert_header_stream_if.slave (input stream, output stream,
//          header channel)
//
// Optional build macro AXIS_INS_STATS_EN adds:
//   pkt_cnt  - output packets accepted downstream (wraps at 2^32)
//   byte_cnt - output bytes accepted downstream   (wraps at 2^32)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module axis_insert_header_stream #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                       clk,
    input  logic                       rst,
    axis_insert_header_stream_if.slave bus
`ifdef AXIS_INS_STATS_EN
    ,
    output logic [31:0]                pkt_cnt,
    output logic [31:0]                byte_cnt
`endif
);

    localparam int CNT_W = BYTE_CNT_WD + 1;   // holds 0..DATA_BYTE_WD
    localparam int TOT_W = BYTE_CNT_WD + 2;   // holds 0..2*DATA_BYTE_WD
    localparam int CAT_W = 2 * DATA_WD;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH
    } state_t;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic [TOT_W-1:0] popcount(input logic [DATA_BYTE_WD-1:0] k);
        logic [TOT_W-1:0] c;
        c = '0;
        for (int b = 0; b < DATA_BYTE_WD; b++) begin
            c = c + TOT_W'(k[b]);
        end
        return c;
    endfunction

    // cnt leading ones from the MSB side (MSB-contiguous keep)
    function automatic logic [DATA_BYTE_WD-1:0] lead_ones(input logic [TOT_W-1:0] cnt);
        logic [DATA_BYTE_WD-1:0] m;
        m = '0;
        for (int b = 0; b < DATA_BYTE_WD; b++) begin
            if (b < int'(cnt)) begin
                m[DATA_BYTE_WD-1-b] = 1'b1;
            end
        end
        return m;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t                  state;
    logic [DATA_WD-1:0]      res_data;     // residual bytes, MSB-aligned
    logic [CNT_W-1:0]        res_cnt;

    logic                    out_valid;
    logic [DATA_WD-1:0]      out_data;
    logic [DATA_BYTE_WD-1:0] out_keep;
    logic                    out_last;
    logic                    ins_ready;

    // -------------------------------------------------------------------------
    // Combinational merge of residual and incoming beat
    // -------------------------------------------------------------------------
    logic                    slot_free;
    logic                    in_ready;
    logic [DATA_WD-1:0]      data_masked;
    logic [TOT_W-1:0]        n_in;
    logic [TOT_W-1:0]        total;
    logic [TOT_W-1:0]        total_minus_full;
    logic                    total_ge_full;
    logic                    total_gt_full;
    logic [CAT_W-1:0]        cat;
    logic [DATA_WD-1:0]      cat_hi;
    logic [DATA_WD-1:0]      cat_lo;
    logic [CNT_W-1:0]        hdr_cnt;
    logic [DATA_WD-1:0]      hdr_aligned;
    logic                    unused_keep_insert;

    // keep_insert is redundant with byte_insert_cnt; only the count is used.
    assign unused_keep_insert = ^bus.keep_insert;

    assign slot_free = !out_valid || bus.ready_out;
    assign in_ready  = (state == STREAM) && slot_free;

    // Zero disabled bytes so stale lanes never leak into the residual.
    always_comb begin
        data_masked = '0;
        for (int b = 0; b < DATA_BYTE_WD; b++) begin
            if (bus.keep_in[b]) begin
                data_masked[8*b +: 8] = bus.data_in[8*b +: 8];
            end
        end
    end

    assign n_in             = popcount(bus.keep_in);
    assign total            = TOT_W'(res_cnt) + n_in;
    assign total_ge_full    = int'(total) >= DATA_BYTE_WD;
    assign total_gt_full    = int'(total) > DATA_BYTE_WD;
    assign total_minus_full = total - TOT_W'(DATA_BYTE_WD);

    // Input bytes are placed directly after the res_cnt residual bytes; the
    // upper word is the candidate output beat, the lower word the leftover.
    assign cat    = {res_data, {DATA_WD{1'b0}}}
                  | ({{DATA_WD{1'b0}}, data_masked} << (8 * (DATA_BYTE_WD - int'(res_cnt))));
    assign cat_hi = cat[CAT_W-1 -: DATA_WD];
    assign cat_lo = cat[DATA_WD-1:0];

    // Counts above the beat width are clamped to a full-beat header.
    assign hdr_cnt     = (int'(bus.byte_insert_cnt) > DATA_BYTE_WD) ? CNT_W'(DATA_BYTE_WD)
                                                                     : bus.byte_insert_cnt;
    assign hdr_aligned = bus.header_insert << (8 * (DATA_BYTE_WD - int'(hdr_cnt)));

    // -------------------------------------------------------------------------
    // FSM, residual and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            res_data  <= '0;
            res_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            ins_ready <= 1'b1;
        end else begin
            // A consumed beat frees the slot unless a new one is loaded below.
            if (out_valid && bus.ready_out) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (bus.valid_insert && ins_ready) begin
                        res_data  <= hdr_aligned;
                        res_cnt   <= hdr_cnt;
                        ins_ready <= 1'b0;
                        state     <= STREAM;
                    end
                end

                STREAM: begin
                    if (bus.valid_in && in_ready) begin
                        if (bus.last_in && !total_gt_full) begin
                            // Whole tail fits into one beat: close the packet.
                            out_valid <= 1'b1;
                            out_data  <= cat_hi;
                            out_keep  <= lead_ones(total);
                            out_last  <= 1'b1;
                            res_data  <= '0;
                            res_cnt   <= '0;
                            ins_ready <= 1'b1;
                            state     <= IDLE;
                        end else if (total_ge_full) begin
                            out_valid <= 1'b1;
                            out_data  <= cat_hi;
                            out_keep  <= '1;
                            out_last  <= 1'b0;
                            res_data  <= cat_lo;
                            res_cnt   <= CNT_W'(total_minus_full);
                            if (bus.last_in) begin
                                state <= FLUSH;
                            end
                        end else begin
                            // Short non-last beat: accumulate, nothing to emit.
                            res_data <= cat_hi;
                            res_cnt  <= CNT_W'(total);
                        end
                    end
                end

                FLUSH: begin
                    if (slot_free) begin
                        out_valid <= 1'b1;
                        out_data  <= res_data;
                        out_keep  <= lead_ones(TOT_W'(res_cnt));
                        out_last  <= 1'b1;
                        res_data  <= '0;
                        res_cnt   <= '0;
                        ins_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready_in     = in_ready;
    assign bus.valid_out    = out_valid;
    assign bus.data_out     = out_data;
    assign bus.keep_out     = out_keep;
    assign bus.last_out     = out_last;
    assign bus.ready_insert = ins_ready;

`ifdef AXIS_INS_STATS_EN
    // -------------------------------------------------------------------------
    // Output statistics
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt  <= '0;
            byte_cnt <= '0;
        end else if (out_valid && bus.ready_out) begin
            if (out_last) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
            byte_cnt <= byte_cnt + 32'(popcount(out_keep));
        end
    end
`endif

endmodule

// File: tb/tb_axis_insert_header_stream.sv
`timescale 1ns/1ps

module tb_axis_insert_header_stream;

    localparam int DW = 32;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } beat_t;

    typedef struct {
        logic [31:0] hdr;
        int          cnt;
        int          nin;
        logic [31:0] din [2];
        logic [3:0]  kin [2];
        int          nout;
        beat_t       exp [3];
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axis_insert_header_stream_if #(.DATA_WD(DW)) bus ();

`ifdef AXIS_INS_STATS_EN
    logic [31:0] pkt_cnt;
    logic [31:0] byte_cnt;
`endif

    axis_insert_header_stream #(.DATA_WD(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef AXIS_INS_STATS_EN
        ,
        .pkt_cnt  (pkt_cnt),
        .byte_cnt (byte_cnt)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic        sink_rand = 1'b0;
    logic        sink_level = 1'b1;
    beat_t       exp_q [$];
    logic [31:0] tx_d [$];
    logic [3:0]  tx_k [$];
    logic [7:0]  pay_q [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every accepted output beat is compared with the model queue;
    // a beat stalled by ready_out must be held unchanged on the next cycle.
    task automatic monitor();
        logic        stall;
        logic [31:0] pd;
        logic [3:0]  pk;
        logic        pl;
        beat_t       e;
        stall = 1'b0;
        pd = '0;
        pk = '0;
        pl = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (stall) begin
                    chk("stall_hold", {26'd0, bus.valid_out, bus.data_out, bus.keep_out, bus.last_out},
                        {26'd0, 1'b1, pd, pk, pl});
                end
                if (bus.valid_out && bus.ready_out) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", {27'd0, bus.data_out, bus.keep_out, bus.last_out}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", {27'd0, bus.data_out, bus.keep_out, bus.last_out},
                            {27'd0, e.d, e.k, e.l});
                    end
                end
                stall = bus.valid_out && !bus.ready_out;
                pd = bus.data_out;
                pk = bus.keep_out;
                pl = bus.last_out;
            end else begin
                stall = 1'b0;
            end
        end
    endtask

    task automatic sink();
        forever begin
            @(posedge clk);
            #1;
            bus.ready_out = sink_rand ? ($urandom_range(0, 99) < 60) : sink_level;
        end
    endtask

    // which=0: header channel, which=1: input stream
    task automatic wait_hs(input int which, input string nm);
        logic got;
        int   t;
        got = 1'b0;
        t = 0;
        while (!got && t < 2000) begin
            @(negedge clk);
            got = (which == 0) ? (bus.valid_insert && bus.ready_insert)
                               : (bus.valid_in && bus.ready_in);
            @(posedge clk);
            #1;
            t++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s: handshake timeout got 0 expected 1", nm);
        end
    endtask

    task automatic send_pkt(input logic [31:0] hdr, input int cnt, input int gap_pct);
        int c;
        c = (cnt > 4) ? 4 : cnt;
        bus.valid_insert    = 1'b1;
        bus.header_insert   = hdr;
        bus.byte_insert_cnt = 3'(cnt);
        bus.keep_insert     = 4'((1 << c) - 1);
        wait_hs(0, "hdr_accept");
        bus.valid_insert = 1'b0;
        for (int i = 0; i < tx_d.size(); i++) begin
            if ($urandom_range(0, 99) < gap_pct) begin
                bus.valid_in = 1'b0;
                @(posedge clk);
                #1;
            end
            bus.valid_in = 1'b1;
            bus.data_in  = tx_d[i];
            bus.keep_in  = tx_k[i];
            bus.last_in  = (i == tx_d.size() - 1);
            wait_hs(1, "beat_accept");
        end
        bus.valid_in = 1'b0;
        bus.last_in  = 1'b0;
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || bus.valid_out) && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Reference model: output byte stream = header bytes then payload bytes,
    // cut into DW/8-byte beats, last flag on the final beat.
    task automatic model_expect(input logic [31:0] hdr, input int cnt);
        logic [7:0] s [$];
        beat_t      b;
        int         c;
        c = (cnt > 4) ? 4 : cnt;
        for (int i = c - 1; i >= 0; i--) s.push_back(hdr[8*i +: 8]);
        foreach (pay_q[i]) s.push_back(pay_q[i]);
        if (s.size() == 0) begin
            b.d = '0; b.k = '0; b.l = 1'b1;
            exp_q.push_back(b);
        end
        while (s.size() > 0) begin
            b.d = '0; b.k = '0;
            for (int j = 0; j < 4; j++) begin
                if (s.size() > 0) begin
                    b.d[31-8*j -: 8] = s.pop_front();
                    b.k[3-j] = 1'b1;
                end
            end
            b.l = (s.size() == 0);
            exp_q.push_back(b);
        end
    endtask

    task automatic rand_packet(input int cnt, input int len);
        logic [31:0] hdr;
        logic [31:0] d;
        logic [3:0]  k;
        int          n;
        int          nb;
        int          idx;
        hdr = $urandom;
        n = (len > 0) ? len : $urandom_range(1, 17);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
        nb = (n + 3) / 4;
        tx_d.delete();
        tx_k.delete();
        for (int b = 0; b < nb; b++) begin
            d = $urandom;
            k = '0;
            for (int j = 0; j < 4; j++) begin
                idx = 4 * b + j;
                if (idx < n) begin
                    d[31-8*j -: 8] = pay_q[idx];
                    k[3-j] = 1'b1;
                end
            end
            tx_d.push_back(d);
            tx_k.push_back(k);
        end
        model_expect(hdr, cnt);
        send_pkt(hdr, cnt, 20);
    endtask

    function automatic vec_t mkv(
        logic [31:0] hdr, int cnt, int nin,
        logic [31:0] d0, logic [3:0] k0, logic [31:0] d1, logic [3:0] k1,
        int nout,
        logic [31:0] o0, logic [3:0] ok0, logic ol0,
        logic [31:0] o1, logic [3:0] ok1, logic ol1,
        logic [31:0] o2, logic [3:0] ok2, logic ol2);
        vec_t v;
        v.hdr = hdr; v.cnt = cnt; v.nin = nin;
        v.din[0] = d0; v.kin[0] = k0; v.din[1] = d1; v.kin[1] = k1;
        v.nout = nout;
        v.exp[0].d = o0; v.exp[0].k = ok0; v.exp[0].l = ol0;
        v.exp[1].d = o1; v.exp[1].k = ok1; v.exp[1].l = ol1;
        v.exp[2].d = o2; v.exp[2].k = ok2; v.exp[2].l = ol2;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input string nm);
        for (int j = 0; j < v.nout; j++) exp_q.push_back(v.exp[j]);
        tx_d.delete();
        tx_k.delete();
        for (int j = 0; j < v.nin; j++) begin
            tx_d.push_back(v.din[j]);
            tx_k.push_back(v.kin[j]);
        end
        send_pkt(v.hdr, v.cnt, 0);
        drain(nm);
    endtask

    initial begin
        vec_t        vt [8];
        logic [31:0] pt [8];
        beat_t       b;
        int          c;

        vt[0] = mkv(32'h000000AA, 1, 2, 32'h11223344, 4'hF, 32'h55660000, 4'hC, 2,
                    32'hAA112233, 4'hF, 1'b0, 32'h44556600, 4'hE, 1'b1, 32'h0, 4'h0, 1'b0);
        vt[1] = mkv(32'h00AABBCC, 3, 1, 32'h11223344, 4'hF, 32'h0, 4'h0, 2,
                    32'hAABBCC11, 4'hF, 1'b0, 32'h22334400, 4'hE, 1'b1, 32'h0, 4'h0, 1'b0);
        vt[2] = mkv(32'hDEADBEEF, 0, 2, 32'h12345678, 4'hF, 32'h9ABC0000, 4'hC, 2,
                    32'h12345678, 4'hF, 1'b0, 32'h9ABC0000, 4'hC, 1'b1, 32'h0, 4'h0, 1'b0);
        vt[3] = mkv(32'h01020304, 7, 1, 32'hA0B0C0D0, 4'h8, 32'h0, 4'h0, 2,
                    32'h01020304, 4'hF, 1'b0, 32'hA0000000, 4'h8, 1'b1, 32'h0, 4'h0, 1'b0);
        vt[4] = mkv(32'h00000000, 0, 1, 32'h11111111, 4'h0, 32'h0, 4'h0, 1,
                    32'h00000000, 4'h0, 1'b1, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0);
        vt[5] = mkv(32'h00000000, 0, 2, 32'hCAFEF00D, 4'hF, 32'h99999999, 4'h0, 2,
                    32'hCAFEF00D, 4'hF, 1'b0, 32'h00000000, 4'h0, 1'b1, 32'h0, 4'h0, 1'b0);
        vt[6] = mkv(32'h0000BBCC, 2, 2, 32'h11223344, 4'hF, 32'h55667788, 4'hF, 3,
                    32'hBBCC1122, 4'hF, 1'b0, 32'h33445566, 4'hF, 1'b0, 32'h77880000, 4'hC, 1'b1);
        vt[7] = mkv(32'h000000EE, 1, 1, 32'h11223344, 4'hE, 32'h0, 4'h0, 1,
                    32'hEE112233, 4'hF, 1'b1, 32'h0, 4'h0, 1'b0, 32'h0, 4'h0, 1'b0);

        bus.valid_in = 1'b0; bus.data_in = '0; bus.keep_in = '0; bus.last_in = 1'b0;
        bus.ready_out = 1'b1;
        bus.valid_insert = 1'b0; bus.header_insert = '0; bus.keep_insert = '0;
        bus.byte_insert_cnt = '0;

        fork
            monitor();
            sink();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_in", 64'(bus.ready_in), 64'd0);
        chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
        chk("rst_data_out", 64'(bus.data_out), 64'd0);
        chk("rst_keep_out", 64'(bus.keep_out), 64'd0);
        chk("rst_last_out", 64'(bus.last_out), 64'd0);
        chk("rst_ready_insert", 64'(bus.ready_insert), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            run_vec(vt[i], $sformatf("vec%0d", i));
        end

        // FLUSH under backpressure: input closed while the residual drains
        sink_level = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        exp_q.push_back(vt[1].exp[0]);
        exp_q.push_back(vt[1].exp[1]);
        tx_d.delete(); tx_k.delete();
        tx_d.push_back(32'h11223344); tx_k.push_back(4'hF);
        send_pkt(32'h00AABBCC, 3, 0);
        repeat (3) begin
            @(negedge clk);
            chk("flush_ready_in", 64'(bus.ready_in), 64'd0);
            chk("flush_ready_insert", 64'(bus.ready_insert), 64'd0);
            chk("flush_valid_held", {31'd0, bus.valid_out, bus.data_out}, {31'd0, 1'b1, 32'hAABBCC11});
        end
        sink_level = 1'b1;
        drain("flush");
        @(negedge clk);
        chk("flush_idle_ready_insert", 64'(bus.ready_insert), 64'd1);
        @(posedge clk);
        #1;

        // Pass-through, no bubbles, 1-cycle latency
        bus.valid_insert = 1'b1; bus.header_insert = 32'h55AA55AA;
        bus.byte_insert_cnt = 3'd0; bus.keep_insert = 4'h0;
        wait_hs(0, "pt_hdr");
        bus.valid_insert = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pt[i] = $urandom;
            b.d = pt[i]; b.k = 4'hF; b.l = (i == 7);
            exp_q.push_back(b);
        end
        for (int i = 0; i < 8; i++) begin
            bus.valid_in = 1'b1; bus.data_in = pt[i]; bus.keep_in = 4'hF; bus.last_in = (i == 7);
            @(negedge clk);
            chk("pt_ready_in", 64'(bus.ready_in), 64'd1);
            chk("pt_ready_insert", 64'(bus.ready_insert), 64'd0);
            if (i > 0) chk("pt_latency", {31'd0, bus.valid_out, bus.data_out}, {31'd0, 1'b1, pt[i-1]});
            @(posedge clk);
            #1;
        end
        bus.valid_in = 1'b0; bus.last_in = 1'b0;
        @(negedge clk);
        chk("pt_last_beat", {30'd0, bus.valid_out, bus.last_out, bus.data_out}, {30'd0, 1'b1, 1'b1, pt[7]});
        chk("pt_ready_insert_end", 64'(bus.ready_insert), 64'd1);
        drain("pt");

        // Reset in the middle of a packet
        sink_level = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        bus.valid_insert = 1'b1; bus.header_insert = 32'h0000BEEF;
        bus.byte_insert_cnt = 3'd2; bus.keep_insert = 4'h3;
        wait_hs(0, "mid_hdr");
        bus.valid_insert = 1'b0;
        bus.valid_in = 1'b1; bus.data_in = 32'h11223344; bus.keep_in = 4'hF; bus.last_in = 1'b0;
        wait_hs(1, "mid_beat");
        bus.valid_in = 1'b0;
        mon_en = 1'b0;
        @(negedge clk);
        chk("mid_valid_before_rst", 64'(bus.valid_out), 64'd1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid_out", 64'(bus.valid_out), 64'd0);
        chk("mid_rst_data_out", 64'(bus.data_out), 64'd0);
        chk("mid_rst_keep_last", {62'd0, |bus.keep_out, bus.last_out}, 64'd0);
        chk("mid_rst_ready_in", 64'(bus.ready_in), 64'd0);
        chk("mid_rst_ready_insert", 64'(bus.ready_insert), 64'd1);
        exp_q.delete();
        mon_en = 1'b1;
        sink_level = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        run_vec(vt[0], "after_rst");

        // Randomized traffic with backpressure against the byte-stream model
        sink_rand = 1'b1;
        for (int p = 0; p < 140; p++) begin
            c = (p < 100) ? 4 : $urandom_range(0, 7);
            rand_packet(c, 0);
        end
        drain("rand");
        sink_rand = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

`ifdef AXIS_INS_STATS_EN
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rand_packet(1, 4);
        rand_packet(2, 4);
        rand_packet(4, 5);
        drain("stats");
        @(negedge clk);
        chk("stats_pkt_cnt", 64'(pkt_cnt), 64'd3);
        chk("stats_byte_cnt", 64'(byte_cnt), 64'd20);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
